// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle sequencing controller for the 4-bit-opcode RISC datapath.
// Steps FETCH/DECODE/EXEC/MEM/WB, stalls on mem_ready, faults on memory timeout, counts retirements.
module multicycle_ctrl_fsm #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             run,
  input  logic [3:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic [2:0]       state,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             ir_write,
  output logic             iord,
  output logic             mem_read,
  output logic             mem_write,
  output logic             alu_src,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             mem_to_reg,
  output logic             reg_write,
  output logic             err,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [2:0] S_FETCH  = 3'd0;
  localparam logic [2:0] S_DECODE = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd2;
  localparam logic [2:0] S_MEM    = 3'd3;
  localparam logic [2:0] S_WB     = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;

  localparam logic [3:0] OP_LW  = 4'b0000;
  localparam logic [3:0] OP_SW  = 4'b0001;
  localparam logic [3:0] OP_BEQ = 4'b1100;
  localparam logic [3:0] OP_BNE = 4'b1101;
  localparam logic [3:0] OP_JMP = 4'b1110;

  localparam logic [1:0] PC_SRC_INC    = 2'b00;
  localparam logic [1:0] PC_SRC_BRANCH = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] ALU_OP_FUNCT = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_ADDR  = 2'b10;

  localparam int              WAIT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_q;
  logic              err_q;
  logic [CNT_W-1:0]  count_q;

  logic is_lw, is_sw, is_beq, is_bne, is_jmp, is_dtype;
  logic waiting, timeout, retire;

  // Undefined opcodes fall into the D-type class rather than trapping.
  assign is_lw    = (opcode == OP_LW);
  assign is_sw    = (opcode == OP_SW);
  assign is_beq   = (opcode == OP_BEQ);
  assign is_bne   = (opcode == OP_BNE);
  assign is_jmp   = (opcode == OP_JMP);
  assign is_dtype = !(is_lw || is_sw || is_beq || is_bne || is_jmp);

  // NOTE: every signal written in a combinational block gets a default first so no latch is inferred.
  always_comb begin
    state_d = state_q;
    waiting = 1'b0;
    retire  = 1'b0;
    case (state_q)
      S_FETCH: begin
        if (run) begin
          if (mem_ready) state_d = S_DECODE;
          else           waiting = 1'b1;
        end
      end
      S_DECODE: begin
        if (is_jmp) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (is_lw || is_sw) begin
          state_d = S_MEM;
        end else if (is_beq || is_bne) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        if (!mem_ready) begin
          waiting = 1'b1;
        end else if (is_sw) begin
          state_d = S_FETCH;
          retire  = 1'b1;
        end else begin
          state_d = S_WB;
        end
      end
      S_WB: begin
        state_d = S_FETCH;
        retire  = 1'b1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_FETCH;
    endcase

    // A ready response in the limit cycle takes the normal path above; only a stall faults.
    timeout = waiting && (wait_q == WAIT_LAST);
    if (timeout) state_d = S_HALT;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      wait_q  <= '0;
      err_q   <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      // The counter only survives while stalled in the same state; any move or idle FETCH clears it.
      if (waiting && !timeout) wait_q <= wait_q + 1'b1;
      else                     wait_q <= '0;
      if (timeout) err_q   <= 1'b1;
      if (retire)  count_q <= count_q + 1'b1;
    end
  end

  always_comb begin
    pc_write   = 1'b0;
    pc_src     = PC_SRC_INC;
    ir_write   = 1'b0;
    iord       = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_OP_FUNCT;
    reg_dst    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    if (rst_n) begin
      case (state_q)
        S_FETCH: begin
          if (run) begin
            mem_read = 1'b1;
            if (mem_ready) begin
              ir_write = 1'b1;
              pc_write = 1'b1;
            end
          end
        end
        S_DECODE: begin
          if (is_jmp) begin
            pc_write = 1'b1;
            pc_src   = PC_SRC_JUMP;
          end
        end
        S_EXEC: begin
          if (is_lw || is_sw) begin
            alu_src = 1'b1;
            alu_op  = ALU_OP_ADDR;
          end else if (is_beq || is_bne) begin
            alu_op   = ALU_OP_SUB;
            pc_src   = PC_SRC_BRANCH;
            pc_write = is_beq ? zero : !zero;
          end
        end
        S_MEM: begin
          iord      = 1'b1;
          mem_read  = !is_sw;
          mem_write = is_sw;
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = is_lw;
          reg_dst    = is_dtype;
        end
        default: ;
      endcase
    end
  end

  assign state       = state_q;
  assign err         = err_q;
  assign instr_count = count_q;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Scoreboarded random/directed bench for multicycle_ctrl_fsm.
// Stimulus walks whole instructions through a class-level model; a negedge monitor compares every cycle.
module tb_multicycle_ctrl_fsm;

  localparam int TO = 4;
  localparam int CW = 2;

  localparam logic [2:0] FETCH  = 3'd0;
  localparam logic [2:0] DECODE = 3'd1;
  localparam logic [2:0] EXEC   = 3'd2;
  localparam logic [2:0] MEM    = 3'd3;
  localparam logic [2:0] WB     = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  typedef enum {C_LW, C_SW, C_D, C_BEQ, C_BNE, C_JMP} cls_t;

  typedef struct packed {
    logic [2:0]    state;
    logic          pc_write;
    logic [1:0]    pc_src;
    logic          ir_write;
    logic          iord;
    logic          mem_read;
    logic          mem_write;
    logic          alu_src;
    logic [1:0]    alu_op;
    logic          reg_dst;
    logic          mem_to_reg;
    logic          reg_write;
    logic          err;
    logic [CW-1:0] cnt;
  } obs_t;

  logic clk = 1'b0;
  logic rst_n, run, zero, mem_ready;
  logic [3:0] opcode;
  logic [2:0] state;
  logic pc_write, ir_write, iord, mem_read, mem_write, alu_src, reg_dst, mem_to_reg, reg_write, err;
  logic [1:0] pc_src, alu_op;
  logic [CW-1:0] instr_count;

  obs_t  sb[$];
  string sb_tag[$];
  string cur_tag;
  int    compared = 0;
  int    mismatched = 0;
  bit    exp_err;
  int    exp_count;

  always #5 clk = ~clk;

  multicycle_ctrl_fsm #(.TIMEOUT_CYCLES(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .state(state), .pc_write(pc_write), .pc_src(pc_src), .ir_write(ir_write), .iord(iord),
    .mem_read(mem_read), .mem_write(mem_write), .alu_src(alu_src), .alu_op(alu_op),
    .reg_dst(reg_dst), .mem_to_reg(mem_to_reg), .reg_write(reg_write), .err(err),
    .instr_count(instr_count)
  );

  function automatic cls_t classify(input logic [3:0] op);
    case (op)
      4'd0:    return C_LW;
      4'd1:    return C_SW;
      4'd12:   return C_BEQ;
      4'd13:   return C_BNE;
      4'd14:   return C_JMP;
      default: return C_D;
    endcase
  endfunction

  // Expected datapath controls for one cycle, from the instruction-class tables.
  function automatic obs_t expect_obs(input logic [2:0] st);
    obs_t e;
    cls_t c;
    e       = '0;
    e.state = st;
    e.err   = exp_err;
    e.cnt   = CW'(exp_count);
    c       = classify(opcode);
    if (rst_n) begin
      if (st == FETCH && run) begin
        e.mem_read = 1'b1;
        e.ir_write = mem_ready;
        e.pc_write = mem_ready;
      end else if (st == DECODE && c == C_JMP) begin
        e.pc_write = 1'b1;
        e.pc_src   = 2'b10;
      end else if (st == EXEC && (c == C_LW || c == C_SW)) begin
        e.alu_src = 1'b1;
        e.alu_op  = 2'b10;
      end else if (st == EXEC && (c == C_BEQ || c == C_BNE)) begin
        e.alu_op   = 2'b01;
        e.pc_src   = 2'b01;
        e.pc_write = (c == C_BEQ) ? zero : !zero;
      end else if (st == MEM) begin
        e.iord      = 1'b1;
        e.mem_read  = (c == C_LW);
        e.mem_write = (c == C_SW);
      end else if (st == WB) begin
        e.reg_write  = 1'b1;
        e.mem_to_reg = (c == C_LW);
        e.reg_dst    = (c == C_D);
      end
    end
    return e;
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      obs_t  e, got;
      string tag;
      e   = sb.pop_front();
      tag = sb_tag.pop_front();
      got = {state, pc_write, pc_src, ir_write, iord, mem_read, mem_write, alu_src, alu_op,
             reg_dst, mem_to_reg, reg_write, err, instr_count};
      compared++;
      if (got !== e) begin
        mismatched++;
        $display("FAIL %s @%0t: got state=%0d vec=%h, expected state=%0d vec=%h",
                 tag, $time, got.state, got, e.state, e);
      end
    end
  end

  // One clock cycle: inputs are set here, the expectation queued, then the edge consumed.
  task automatic cyc(input logic [2:0] st, input bit rdy, input bit z);
    mem_ready = rdy;
    zero      = z;
    sb.push_back(expect_obs(st));
    sb_tag.push_back(cur_tag);
    @(posedge clk);
    #1;
  endtask

  function automatic bit rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic retire();
    exp_count = (exp_count + 1) % (1 << CW);
  endtask

  // Stall nwait cycles, then ready; a stall reaching TO cycles ends in HALT.
  task automatic wait_phase(input logic [2:0] st, input int nwait, output bit fault);
    fault = 1'b0;
    for (int i = 0; i <= nwait; i++) begin
      if (i == nwait) begin
        cyc(st, 1'b1, rb());
      end else begin
        cyc(st, 1'b0, rb());
        if (i == TO - 1) begin
          fault   = 1'b1;
          exp_err = 1'b1;
          return;
        end
      end
    end
  endtask

  task automatic run_instr(input logic [3:0] op, input bit z, input int fw, input int mw,
                           output bit fault);
    cls_t c;
    run    = 1'b1;
    opcode = 4'($urandom);
    wait_phase(FETCH, fw, fault);
    if (fault) return;
    opcode = op;
    c      = classify(op);
    cyc(DECODE, rb(), rb());
    if (c == C_JMP) begin
      retire();
      return;
    end
    cyc(EXEC, rb(), z);
    if (c == C_BEQ || c == C_BNE) begin
      retire();
      return;
    end
    if (c == C_LW || c == C_SW) begin
      wait_phase(MEM, mw, fault);
      if (fault) return;
      if (c == C_SW) begin
        retire();
        return;
      end
    end
    cyc(WB, rb(), rb());
    retire();
  endtask

  task automatic do_reset(input logic [2:0] cur_state);
    rst_n = 1'b0;
    run   = rb();
    cyc(cur_state, rb(), rb());
    rst_n     = 1'b1;
    exp_err   = 1'b0;
    exp_count = 0;
  endtask

  task automatic halt_hold(input int n);
    for (int i = 0; i < n; i++) begin
      run    = rb();
      opcode = 4'($urandom);
      cyc(HALT, rb(), rb());
    end
  endtask

  task automatic idle(input int n);
    run = 1'b0;
    for (int i = 0; i < n; i++) cyc(FETCH, rb(), rb());
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, compared=%0d", compared);
    $fatal(1, "watchdog");
  end

  initial begin
    bit   fault;
    int   fw, mw;
    logic [3:0] op;
    rst_n = 1'b0; run = 1'b0; opcode = 4'd0; zero = 1'b0; mem_ready = 1'b0;
    exp_err = 1'b0; exp_count = 0;
    repeat (2) @(posedge clk);
    #1;

    cur_tag = "reset";      do_reset(FETCH);
    cur_tag = "dtype";      run_instr(4'b0010, 1'b0, 0, 0, fault);
    cur_tag = "lw_stall3";  run_instr(4'b0000, 1'b0, 0, 3, fault);
    cur_tag = "beq_z1";     run_instr(4'b1100, 1'b1, 0, 0, fault);
    cur_tag = "bne_z1";     run_instr(4'b1101, 1'b1, 0, 0, fault);
    cur_tag = "beq_z0";     run_instr(4'b1100, 1'b0, 0, 0, fault);
    cur_tag = "bne_z0";     run_instr(4'b1101, 1'b0, 0, 0, fault);
    cur_tag = "jmp";        run_instr(4'b1110, 1'b0, 0, 0, fault);
    cur_tag = "undef_op";   run_instr(4'b1111, 1'b0, 1, 0, fault);

    cur_tag = "sw_timeout"; run_instr(4'b0001, 1'b0, 0, 100, fault);
    cur_tag = "halt_hold";  halt_hold(3);
    cur_tag = "halt_reset"; do_reset(HALT);
    cur_tag = "sw_limit_ready"; run_instr(4'b0001, 1'b0, 0, TO - 1, fault);

    cur_tag = "jmp_wrap";
    for (int i = 0; i < 5; i++) run_instr(4'b1110, 1'b0, 0, 0, fault);

    cur_tag = "run_low";    idle(3);
    cur_tag = "fetch_clear";
    run = 1'b1;
    cyc(FETCH, 1'b0, 1'b0);
    cyc(FETCH, 1'b0, 1'b0);
    idle(1);
    run_instr(4'b0011, 1'b0, TO - 1, 0, fault);

    cur_tag = "fetch_timeout"; run_instr(4'b0000, 1'b0, TO, 0, fault);
    halt_hold(2);
    do_reset(HALT);

    cur_tag = "mid_reset";
    run = 1'b1; opcode = 4'b0000;
    cyc(FETCH, 1'b1, 1'b0);
    cyc(DECODE, 1'b0, 1'b0);
    cyc(EXEC, 1'b0, 1'b0);
    do_reset(MEM);

    cur_tag = "random";
    for (int n = 0; n < 300; n++) begin
      op = 4'($urandom);
      fw = ($urandom_range(0, 15) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 15) == 0) ? $urandom_range(0, TO + 1) : $urandom_range(0, 2);
      if ($urandom_range(0, 9) == 0) idle($urandom_range(1, 3));
      run_instr(op, rb(), fw, mw, fault);
      if (fault) begin
        halt_hold(2);
        do_reset(HALT);
      end
    end

    repeat (2) @(posedge clk);
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: %0d expectations left, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl_fsm.md
Name: multicycle_ctrl_fsm

Overview:
Multi-cycle sequencing controller for the 4-bit-opcode RISC datapath. It steps each instruction through FETCH, DECODE, EXEC, MEM and WB, and issues per-state datapath strobes. It stalls on a memory-ready handshake, detects memory timeouts, and counts retired instructions. It sits between the instruction register (opcode source) and the shared single-port memory, ALU, register file and PC.

Parameters:
TIMEOUT_CYCLES, 16, mem_ready-low cycles tolerated in a wait state before the controller faults (minimum 1)
CNT_W, 16, width of the retired-instruction counter

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
run  input  1  permits a new fetch; sampled only in FETCH
opcode  input  4  current instruction opcode from IR
zero  input  1  ALU zero flag, valid in EXEC
mem_ready  input  1  memory has completed the current read/write this cycle
state  output  3  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5
pc_write  output  1  PC load enable
pc_src  output  2  00 = PC+1, 01 = branch target, 10 = jump target
ir_write  output  1  IR load enable
iord  output  1  memory address select: 0 = PC, 1 = ALU result
mem_read  output  1  memory read strobe
mem_write  output  1  memory write strobe
alu_src  output  1  0 = register operand, 1 = sign-extended immediate
alu_op  output  2  00 = function from opcode, 01 = subtract/compare, 10 = address add, 11 = pass
reg_dst  output  1  0 = rt, 1 = rd
mem_to_reg  output  1  writeback select: 1 = memory data
reg_write  output  1  register-file write enable
err  output  1  sticky timeout fault
instr_count  output  CNT_W  retired-instruction count

Behaviour:
- Registered elements: state, wait counter, err, instr_count. All strobes are combinational decodes of state, opcode and zero, with zero latency. Unlisted strobes are 0 and pc_src/alu_op are 00.
- Reset (rst_n=0 at an edge): state=FETCH, wait counter=0, err=0, instr_count=0. While rst_n=0, all strobes are forced to 0. Reset overrides everything, including mid-instruction.
- Opcode classes:
  - LW=0000, SW=0001.
  - D-type = 0010..1011 and 1111 (undefined opcodes execute as D-type).
  - BEQ=1100, BNE=1101, JMP=1110.
- FETCH:
  - run=0: no strobes, hold state, wait counter held at 0.
  - run=1: mem_read=1, iord=0. On mem_ready=1: ir_write=1, pc_write=1, pc_src=00, go to DECODE.
- DECODE:
  - JMP: pc_write=1, pc_src=10, go to FETCH (retires).
  - All other opcodes: no strobes, go to EXEC.
- EXEC:
  - LW/SW: alu_src=1, alu_op=10, go to MEM.
  - D-type: alu_src=0, alu_op=00, go to WB.
  - BEQ: alu_op=01, pc_src=01, pc_write=zero, go to FETCH (retires).
  - BNE: alu_op=01, pc_src=01, pc_write=~zero, go to FETCH (retires).
- MEM:
  - LW: iord=1, mem_read=1. On mem_ready=1 go to WB.
  - SW: iord=1, mem_write=1. On mem_ready=1 go to FETCH (retires).
  - Strobes stay asserted every wait cycle.
- WB: reg_write=1, go to FETCH (retires).
  - D-type: reg_dst=1, mem_to_reg=0.
  - LW: reg_dst=0, mem_to_reg=1.
- Latency with mem_ready=1 on the first wait cycle: JMP 2, BEQ/BNE 3, SW 4, D-type 4, LW 5 cycles.
- Wait counter:
  - Increments each cycle spent in FETCH (with run=1) or MEM with mem_ready=0. Clears on any state change.
  - When it reaches TIMEOUT_CYCLES with mem_ready still 0, the next state is HALT and err is set.
  - mem_ready=1 in the same cycle as the limit wins: normal transition, no fault.
- HALT: all strobes 0, err=1. Exit only via reset.
- instr_count increments by 1 on every retiring transition into FETCH and wraps modulo 2^CNT_W. It never increments in HALT or on the HALT entry.
- opcode must be stable from DECODE through retirement; the controller does not latch it.

Test Plan:
- Reset then run=1, mem_ready=1 constantly, opcode=0010 → states 0,1,2,4,0; reg_write=1 and reg_dst=1 only in WB; instr_count=1 after 4 cycles.
- LW (0000) with mem_ready low for 3 MEM cycles → MEM held 4 cycles with iord=1 and mem_read=1 throughout; WB has mem_to_reg=1, reg_dst=0; total latency 8 cycles.
- BEQ with zero=1 → pc_write=1, pc_src=01 in EXEC. BNE with zero=1 → pc_write=0. Both return to FETCH after 3 cycles.
- JMP (1110) → pc_write=1, pc_src=10 in DECODE; back in FETCH after 2 cycles; instr_count+1.
- TIMEOUT_CYCLES=4, SW with mem_ready held 0 → HALT after 4 MEM cycles, err=1, mem_write=0 in HALT, instr_count unchanged. rst_n=0 for one edge → FETCH, err=0. Repeat with mem_ready=1 on the 4th wait cycle → no fault.
- CNT_W=2, 5 JMPs → instr_count sequence 1,2,3,0,1. With run=0 in FETCH, no mem_read and state held.
